// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
//   op_t    : operation encoding presented on muldiv_unit.op (code 3 runs as MUL)
//   state_t : sequencing states of muldiv_unit
//   XLEN    : operand/result width
//   ITERS   : radix-2 iterations per operation
//   mag()   : two's-complement magnitude of a 64-bit value
package muldiv_pkg;

    localparam int XLEN  = 64;
    localparam int ITERS = 64;

    typedef enum logic [1:0] {
        MUL  = 2'd0,
        UDIV = 2'd1,
        SDIV = 2'd2
    } op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // The magnitude of INT64_MIN is 2^63, which is still representable unsigned.
    function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] v);
        return v[XLEN-1] ? (~v + {{(XLEN-1){1'b0}}, 1'b1}) : v;
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration, purely combinational.
//   is_div  : 1 = restoring-division step, 0 = shift-add multiply step
//   acc_in  : running product (MUL) or partial remainder (DIV)
//   x_in    : remaining multiplier bits (MUL) or dividend/quotient shift reg (DIV)
//   y_in    : shifted multiplicand (MUL) or divisor magnitude (DIV)
//   acc_out, x_out, y_out : register values after this iteration
module muldiv_step
    import muldiv_pkg::*;
(
    input  logic            is_div,
    input  logic [XLEN-1:0] acc_in,
    input  logic [XLEN-1:0] x_in,
    input  logic [XLEN-1:0] y_in,
    output logic [XLEN-1:0] acc_out,
    output logic [XLEN-1:0] x_out,
    output logic [XLEN-1:0] y_out
);

    logic [XLEN:0]   rem_sh;
    logic [XLEN-1:0] diff;
    logic            ge;

    always_comb begin
        // The remainder stays below the divisor, so after the shift it needs
        // one extra bit; the difference itself always fits in XLEN bits.
        rem_sh = {acc_in, x_in[XLEN-1]};
        ge     = (rem_sh >= {1'b0, y_in});
        diff   = rem_sh[XLEN-1:0] - y_in;

        acc_out = acc_in;
        x_out   = x_in;
        y_out   = y_in;

        if (is_div) begin
            acc_out = ge ? diff : rem_sh[XLEN-1:0];
            x_out   = {x_in[XLEN-2:0], ge};
            y_out   = y_in;
        end else begin
            acc_out = acc_in + (x_in[0] ? y_in : '0);
            x_out   = x_in >> 1;
            y_out   = y_in << 1;
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative 64-bit multiply / unsigned divide / signed divide unit.
// One operation takes 64 iteration cycles plus a result-fixup cycle in RUN,
// then a single DONE cycle that pulses done.
//   clk, reset_n : clock, asynchronous active-low reset
//   start, op    : request and operation code (sampled only in IDLE)
//   a, b         : operand / dividend and operand / divisor
//   dst_in       : destination register index captured with the operands
//   flush        : synchronous abort
//   busy, done   : busy in RUN and DONE, done pulses for one cycle
//   result, dst_out : valid while done=1, driven 0 otherwise
//
// state | meaning
// IDLE  | waiting for start
// RUN   | 64 radix-2 iterations, then one cycle to form the final result
// DONE  | result presented for one cycle, done=1
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [4:0]      dst_in,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [4:0]      dst_out
);

    localparam logic [5:0] CNT_LAST = 6'(ITERS - 1);

    state_t          state;
    logic [5:0]      cnt;
    logic            steps_done;
    logic            is_div;
    logic            neg;
    logic [XLEN-1:0] acc;
    logic [XLEN-1:0] x;
    logic [XLEN-1:0] y;
    logic [4:0]      dst_r;
    logic [XLEN-1:0] acc_nx;
    logic [XLEN-1:0] x_nx;
    logic [XLEN-1:0] y_nx;
    logic [XLEN-1:0] res_fin;
    logic            op_div;
    logic            op_sdiv;

    assign op_div  = (op == UDIV) || (op == SDIV);
    assign op_sdiv = (op == SDIV);

    muldiv_step u_step (
        .is_div  (is_div),
        .acc_in  (acc),
        .x_in    (x),
        .y_in    (y),
        .acc_out (acc_nx),
        .x_out   (x_nx),
        .y_out   (y_nx)
    );

    // The divisor register is never shifted in divide mode, so a zero there
    // identifies divide-by-zero, which returns 0 instead of the all-ones quotient.
    always_comb begin
        res_fin = acc;
        if (is_div) begin
            if (y == '0)
                res_fin = '0;
            else if (neg)
                res_fin = -x;
            else
                res_fin = x;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            cnt        <= '0;
            steps_done <= 1'b0;
            is_div     <= 1'b0;
            neg        <= 1'b0;
            acc        <= '0;
            x          <= '0;
            y          <= '0;
            dst_r      <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            result     <= '0;
            dst_out    <= '0;
        end else if (flush) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            result  <= '0;
            dst_out <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state      <= RUN;
                        busy       <= 1'b1;
                        cnt        <= '0;
                        steps_done <= 1'b0;
                        acc        <= '0;
                        dst_r      <= dst_in;
                        is_div     <= op_div;
                        neg        <= op_sdiv && (a[XLEN-1] ^ b[XLEN-1]);
                        x          <= op_sdiv ? mag(a) : a;
                        y          <= op_sdiv ? mag(b) : b;
                    end
                end
                RUN: begin
                    if (!steps_done) begin
                        acc <= acc_nx;
                        x   <= x_nx;
                        y   <= y_nx;
                        cnt <= cnt + 6'd1;
                        if (cnt == CNT_LAST)
                            steps_done <= 1'b1;
                    end else begin
                        state   <= DONE;
                        done    <= 1'b1;
                        result  <= res_fin;
                        dst_out <= dst_r;
                    end
                end
                DONE: begin
                    state   <= IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                    result  <= '0;
                    dst_out <= '0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: the driver pushes the expected result,
// destination and done edge for every accepted operation; a monitor on the
// falling edge pops and compares whenever done is high.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    localparam logic [63:0] INT_MIN = 64'h8000_0000_0000_0000;
    localparam logic [63:0] INT_MAX = 64'h7FFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] NEG1    = 64'hFFFF_FFFF_FFFF_FFFF;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [1:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    logic [4:0]  dst_in;
    logic        flush;
    logic        busy;
    logic        done;
    logic [63:0] result;
    logic [4:0]  dst_out;

    int     errors = 0;
    int     checks = 0;
    longint cyc = 0;

    typedef struct {
        logic [63:0] res;
        logic [4:0]  dst;
        longint      edge_no;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;

    muldiv_unit #(.XLEN(64)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .op      (op),
        .a       (a),
        .b       (b),
        .dst_in  (dst_in),
        .flush   (flush),
        .busy    (busy),
        .done    (done),
        .result  (result),
        .dst_out (dst_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: plain arithmetic on the operation's definition.
    function automatic logic [63:0] ref_model(input logic [1:0] o, input logic [63:0] x, input logic [63:0] y);
        logic [63:0] r;
        case (o)
            2'd1: r = (y == 0) ? 64'd0 : x / y;
            2'd2: begin
                if (y == 0)
                    r = 64'd0;
                else if (x == INT_MIN && y == NEG1)
                    r = INT_MIN;
                else
                    r = $signed(x) / $signed(y);
            end
            default: r = x * y;
        endcase
        return r;
    endfunction

    function automatic logic [63:0] rand_opnd();
        case ($urandom_range(0, 7))
            0: return 64'd0;
            1: return 64'd1;
            2: return NEG1;
            3: return INT_MIN;
            4: return INT_MAX;
            5: return 64'($urandom_range(0, 100));
            6: return -64'($urandom_range(1, 100));
            default: return {$urandom, $urandom};
        endcase
    endfunction

    always @(negedge clk) begin
        if (reset_n === 1'b1) begin
            if (done === 1'b1) begin
                if (sbq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got done=1 with result %h, expected no pending operation (cycle %0d)", result, cyc);
                end else begin
                    mon_e = sbq.pop_front();
                    check("result", result, mon_e.res);
                    check("dst_out", 64'(dst_out), 64'(mon_e.dst));
                    check("done_edge", 64'(cyc), 64'(mon_e.edge_no + 65));
                    check("busy_during_done", 64'(busy), 64'd1);
                end
            end else begin
                check("result_idle_zero", result, 64'd0);
                check("dst_idle_zero", 64'(dst_out), 64'd0);
            end
        end
    end

    // Called at a falling edge; waits for IDLE, then presents start for one edge.
    task automatic wait_idle();
        int w = 0;
        while (busy !== 1'b0 && w < 300) begin
            @(negedge clk);
            w++;
        end
        if (w >= 300) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: got busy=%b after %0d cycles, expected 0", busy, w);
        end
    endtask

    task automatic issue(input logic [1:0] o, input logic [63:0] x, input logic [63:0] y,
                         input logic [4:0] d, input logic [63:0] exp, input bit expect_done);
        wait_idle();
        op = o; a = x; b = y; dst_in = d; start = 1'b1;
        if (expect_done)
            sbq.push_back('{exp, d, cyc + 1});
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", 64'(busy), 64'd1);
    endtask

    initial begin
        logic [1:0]  ro;
        logic [63:0] ra;
        logic [63:0] rb;
        logic [4:0]  rd;
        int          w;

        reset_n = 1'b0; start = 1'b0; flush = 1'b0;
        op = 2'd0; a = '0; b = '0; dst_in = '0;
        repeat (3) @(negedge clk);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_result", result, 64'd0);
        check("reset_dst", 64'(dst_out), 64'd0);
        reset_n = 1'b1;

        // Directed cases with hand-computed expectations.
        issue(MUL,  64'd7,    NEG1 - 64'd2, 5'd5,  64'hFFFF_FFFF_FFFF_FFEB, 1);
        issue(UDIV, 64'd100,  64'd7,        5'd1,  64'd14, 1);
        issue(SDIV, -64'd100, 64'd7,        5'd2,  64'hFFFF_FFFF_FFFF_FFF2, 1);
        issue(SDIV, -64'd100, -64'd7,       5'd3,  64'd14, 1);
        issue(SDIV, 64'd100,  -64'd7,       5'd7,  64'hFFFF_FFFF_FFFF_FFF2, 1);
        issue(UDIV, 64'd123,  64'd0,        5'd31, 64'd0, 1);
        issue(SDIV, INT_MIN,  NEG1,         5'd4,  INT_MIN, 1);
        issue(2'd3, 64'd6,    64'd9,        5'd6,  64'd54, 1);
        issue(UDIV, NEG1,     64'd1,        5'd8,  NEG1, 1);

        // Start held high with operands changing every cycle: an operation is
        // accepted every 67 edges, each using the operands present at its edge.
        wait_idle();
        start = 1'b1;
        for (int i = 0; i < 4 * 67; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = rand_opnd();
            rb = rand_opnd();
            rd = 5'($urandom_range(0, 31));
            op = ro; a = ra; b = rb; dst_in = rd;
            if (i % 67 == 0)
                sbq.push_back('{ref_model(ro, ra, rb), rd, cyc + 1});
            @(negedge clk);
        end
        start = 1'b0;

        // Flush sampled at the 30th RUN edge aborts without a done.
        issue(MUL, 64'd3, 64'd5, 5'd9, 64'd15, 0);
        repeat (29) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("busy_after_flush", 64'(busy), 64'd0);
        repeat (100) @(negedge clk);

        // Flush and start together in IDLE: nothing is captured.
        op = UDIV; a = 64'd50; b = 64'd5; dst_in = 5'd10;
        start = 1'b1; flush = 1'b1;
        @(negedge clk);
        start = 1'b0; flush = 1'b0;
        check("busy_flush_start", 64'(busy), 64'd0);
        repeat (80) @(negedge clk);

        // Asynchronous reset mid-RUN clears outputs immediately.
        issue(UDIV, 64'd1000, 64'd3, 5'd11, 64'd333, 0);
        repeat (20) @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("async_reset_busy", 64'(busy), 64'd0);
        check("async_reset_done", 64'(done), 64'd0);
        check("async_reset_result", result, 64'd0);
        check("async_reset_dst", 64'(dst_out), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        // First edge after release accepts a start.
        issue(SDIV, -64'd21, 64'd4, 5'd12, -64'd5, 1);

        // Random regression with corner operands.
        for (int n = 0; n < 1000; n++) begin
            ro = 2'($urandom_range(0, 3));
            ra = rand_opnd();
            rb = rand_opnd();
            rd = 5'($urandom_range(0, 31));
            issue(ro, ra, rb, rd, ref_model(ro, ra, rb), 1);
        end

        w = 0;
        while (sbq.size() != 0 && w < 300) begin
            @(negedge clk);
            w++;
        end
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL pending_ops: got %0d outstanding, expected 0", sbq.size());
        end
        repeat (5) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
